// File: rtl/idu_pipe1_sched.sv
// idu_pipe1_sched: 4-entry compacting oldest-first issue queue feeding RF pipe1.
// Define IDU_PIPE1_SCHED_FAST_WAKEUP_EN to let a same-cycle CDB wakeup make an entry eligible.
module idu_pipe1_sched (
    input  logic       clk,
    input  logic       rst_clk,
    input  logic       rtu_global_flush,
    input  logic       dis_vld,
    input  logic [4:0] dis_iid,
    input  logic [6:0] dis_opcode,
    input  logic [6:0] dis_funct7,
    input  logic [2:0] dis_funct3,
    input  logic       dis_psrc1_vld,
    input  logic [5:0] dis_psrc1,
    input  logic       dis_psrc1_rdy,
    input  logic       dis_psrc2_vld,
    input  logic [5:0] dis_psrc2,
    input  logic       dis_psrc2_rdy,
    input  logic       dis_pdst_vld,
    input  logic [5:0] dis_pdst,
    output logic       dis_rdy,
    input  logic       exu_idu_rf_alu_cdb_vld,
    input  logic [5:0] exu_idu_rf_alu_cdb_preg,
    input  logic       exu_idu_rf_mxu_cdb_vld,
    input  logic [5:0] exu_idu_rf_mxu_cdb_preg,
    input  logic       exu_idu_rf_div_cdb_vld,
    input  logic [5:0] exu_idu_rf_div_cdb_preg,
    input  logic       exu_idu_rf_lsu_cdb_vld,
    input  logic [5:0] exu_idu_rf_lsu_cdb_preg,
    input  logic       pipe1_stall,
    output logic       idu_idu_rf_pipe1_vld,
    output logic [4:0] idu_idu_rf_pipe1_iid,
    output logic [6:0] idu_idu_rf_pipe1_opcode,
    output logic [6:0] idu_idu_rf_pipe1_funct7,
    output logic [2:0] idu_idu_rf_pipe1_funct3,
    output logic       idu_idu_rf_pipe1_psrc1_vld,
    output logic [5:0] idu_idu_rf_pipe1_psrc1,
    output logic       idu_idu_rf_pipe1_psrc2_vld,
    output logic [5:0] idu_idu_rf_pipe1_psrc2,
    output logic       idu_idu_rf_pipe1_pdst_vld,
    output logic [5:0] idu_idu_rf_pipe1_pdst,
    output logic [2:0] iq_cnt
);
    typedef struct packed {
        logic [4:0] iid;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       s1v;
        logic [5:0] s1;
        logic       s1r;
        logic       s2v;
        logic [5:0] s2;
        logic       s2r;
        logic       dv;
        logic [5:0] pd;
    } ent_t;
    ent_t [3:0] r_q;
    ent_t [3:0] w_n;
    ent_t [3:0] w_sh;
    ent_t       w_new;
    ent_t       w_o;
    logic [2:0] r_cnt;
    logic [3:0] w_el;
    logic [1:0] w_sel;
    logic       w_any;
    logic       w_iss;
    logic       w_dis;
    logic [2:0] w_slot;
    function automatic logic f_hit(input logic [5:0] p);
        return (exu_idu_rf_alu_cdb_vld && exu_idu_rf_alu_cdb_preg == p) ||
               (exu_idu_rf_mxu_cdb_vld && exu_idu_rf_mxu_cdb_preg == p) ||
               (exu_idu_rf_div_cdb_vld && exu_idu_rf_div_cdb_preg == p) ||
               (exu_idu_rf_lsu_cdb_vld && exu_idu_rf_lsu_cdb_preg == p);
    endfunction
    always_comb begin
        w_n   = r_q;
        w_el  = '0;
        w_sel = '0;
        w_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_n[i].s1r = r_q[i].s1r | (r_q[i].s1v & f_hit(r_q[i].s1));
            w_n[i].s2r = r_q[i].s2r | (r_q[i].s2v & f_hit(r_q[i].s2));
`ifdef IDU_PIPE1_SCHED_FAST_WAKEUP_EN
            w_el[i] = (3'(i) < r_cnt) & w_n[i].s1r & w_n[i].s2r;
`else
            w_el[i] = (3'(i) < r_cnt) & r_q[i].s1r & r_q[i].s2r;
`endif
        end
        for (int i = 3; i >= 0; i--)
            if (w_el[i]) begin
                w_sel = 2'(i);
                w_any = 1'b1;
            end
    end
    // reset also blocks issue so a mid-operation reset discards without issuing
    assign w_iss  = w_any & !pipe1_stall & !rtu_global_flush & !rst_clk;
    assign dis_rdy = (r_cnt < 3'd4) & !rtu_global_flush;
    assign w_dis  = dis_vld & dis_rdy;
    assign w_slot = r_cnt - {2'b0, w_iss};
    assign w_new  = '{iid: dis_iid, op: dis_opcode, f7: dis_funct7, f3: dis_funct3,
                      s1v: dis_psrc1_vld, s1: dis_psrc1,
                      s1r: dis_psrc1_rdy | !dis_psrc1_vld | f_hit(dis_psrc1),
                      s2v: dis_psrc2_vld, s2: dis_psrc2,
                      s2r: dis_psrc2_rdy | !dis_psrc2_vld | f_hit(dis_psrc2),
                      dv: dis_pdst_vld, pd: dis_pdst};
    always_comb begin
        w_sh = w_n;
        for (int i = 0; i < 3; i++)
            if (w_iss && 2'(i) >= w_sel) w_sh[i] = w_n[i+1];
        if (w_dis) w_sh[w_slot[1:0]] = w_new;
    end
    assign w_o = w_iss ? r_q[w_sel] : '0;
    assign idu_idu_rf_pipe1_vld       = w_iss;
    assign idu_idu_rf_pipe1_iid       = w_o.iid;
    assign idu_idu_rf_pipe1_opcode    = w_o.op;
    assign idu_idu_rf_pipe1_funct7    = w_o.f7;
    assign idu_idu_rf_pipe1_funct3    = w_o.f3;
    assign idu_idu_rf_pipe1_psrc1_vld = w_o.s1v;
    assign idu_idu_rf_pipe1_psrc1     = w_o.s1;
    assign idu_idu_rf_pipe1_psrc2_vld = w_o.s2v;
    assign idu_idu_rf_pipe1_psrc2     = w_o.s2;
    assign idu_idu_rf_pipe1_pdst_vld  = w_o.dv;
    assign idu_idu_rf_pipe1_pdst      = w_o.pd;
    assign iq_cnt = r_cnt;
    always_ff @(posedge clk) begin
        if (rst_clk) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else begin
            r_q   <= w_sh;
            r_cnt <= rtu_global_flush ? 3'd0 : r_cnt + {2'b0, w_dis} - {2'b0, w_iss};
        end
    end
endmodule

// File: tb/tb_idu_pipe1_sched.sv
// tb_idu_pipe1_sched: directed scenarios plus random traffic checked against a queue-based model.
module tb_idu_pipe1_sched;
    logic clk = 1'b0;
    logic rst_clk, flush, dis_vld, s1v, s1r, s2v, s2r, dv, stall;
    logic [4:0] iid;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [5:0] s1, s2, pd;
    logic [3:0] cv;
    logic [5:0] cp [4];
    logic dis_rdy, o_vld, o_s1v, o_s2v, o_dv;
    logic [4:0] o_iid;
    logic [6:0] o_op, o_f7;
    logic [2:0] o_f3, cnt;
    logic [5:0] o_s1, o_s2, o_pd;
    logic [43:0] got;
    int chk = 0, errs = 0;
    typedef struct {
        logic [4:0] iid;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic s1v; logic [5:0] s1; logic s1r;
        logic s2v; logic [5:0] s2; logic s2r;
        logic dv; logic [5:0] pd;
    } ent_t;
    ent_t q[$];

    idu_pipe1_sched dut (
        .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(flush),
        .dis_vld(dis_vld), .dis_iid(iid), .dis_opcode(op), .dis_funct7(f7), .dis_funct3(f3),
        .dis_psrc1_vld(s1v), .dis_psrc1(s1), .dis_psrc1_rdy(s1r),
        .dis_psrc2_vld(s2v), .dis_psrc2(s2), .dis_psrc2_rdy(s2r),
        .dis_pdst_vld(dv), .dis_pdst(pd), .dis_rdy(dis_rdy),
        .exu_idu_rf_alu_cdb_vld(cv[0]), .exu_idu_rf_alu_cdb_preg(cp[0]),
        .exu_idu_rf_mxu_cdb_vld(cv[1]), .exu_idu_rf_mxu_cdb_preg(cp[1]),
        .exu_idu_rf_div_cdb_vld(cv[2]), .exu_idu_rf_div_cdb_preg(cp[2]),
        .exu_idu_rf_lsu_cdb_vld(cv[3]), .exu_idu_rf_lsu_cdb_preg(cp[3]),
        .pipe1_stall(stall),
        .idu_idu_rf_pipe1_vld(o_vld), .idu_idu_rf_pipe1_iid(o_iid),
        .idu_idu_rf_pipe1_opcode(o_op), .idu_idu_rf_pipe1_funct7(o_f7),
        .idu_idu_rf_pipe1_funct3(o_f3), .idu_idu_rf_pipe1_psrc1_vld(o_s1v),
        .idu_idu_rf_pipe1_psrc1(o_s1), .idu_idu_rf_pipe1_psrc2_vld(o_s2v),
        .idu_idu_rf_pipe1_psrc2(o_s2), .idu_idu_rf_pipe1_pdst_vld(o_dv),
        .idu_idu_rf_pipe1_pdst(o_pd), .iq_cnt(cnt)
    );
    assign got = {o_vld, o_iid, o_op, o_f7, o_f3, o_s1v, o_s1, o_s2v, o_s2, o_dv, o_pd};
    always #5 clk = ~clk;

    function automatic logic hit(input logic [5:0] p);
        for (int c = 0; c < 4; c++)
            if (cv[c] && cp[c] == p) return 1'b1;
        return 1'b0;
    endfunction

    // oldest queued instruction whose operands are available, -1 if none
    function automatic int pick();
        for (int k = 0; k < q.size(); k++) begin
`ifdef IDU_PIPE1_SCHED_FAST_WAKEUP_EN
            if ((q[k].s1r || (q[k].s1v && hit(q[k].s1))) && (q[k].s2r || (q[k].s2v && hit(q[k].s2))))
                return k;
`else
            if (q[k].s1r && q[k].s2r) return k;
`endif
        end
        return -1;
    endfunction

    task automatic check();
        int k;
        logic [43:0] exp;
        k = pick();
        exp = '0;
        if (k >= 0 && !stall && !flush && !rst_clk)
            exp = {1'b1, q[k].iid, q[k].op, q[k].f7, q[k].f3, q[k].s1v, q[k].s1,
                   q[k].s2v, q[k].s2, q[k].dv, q[k].pd};
        chk++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL bundle t=%0t got=%h exp=%h", $time, got, exp);
        end
        chk++;
        assert (dis_rdy === (q.size() < 4 && !flush)) else begin
            errs++;
            $error("FAIL dis_rdy t=%0t got=%b exp=%b", $time, dis_rdy, q.size() < 4 && !flush);
        end
        chk++;
        assert (cnt === 3'(q.size())) else begin
            errs++;
            $error("FAIL iq_cnt t=%0t got=%0d exp=%0d", $time, cnt, q.size());
        end
    endtask

    task automatic update();
        int k;
        ent_t n;
        if (rst_clk || flush) begin
            q.delete();
            return;
        end
        k = pick();
        n = '{iid, op, f7, f3, s1v, s1, s1r || !s1v || hit(s1), s2v, s2, s2r || !s2v || hit(s2), dv, pd};
        for (int j = 0; j < q.size(); j++) begin
            if (q[j].s1v && hit(q[j].s1)) q[j].s1r = 1'b1;
            if (q[j].s2v && hit(q[j].s2)) q[j].s2r = 1'b1;
        end
        if (k >= 0 && !stall) q.delete(k);
        if (dis_vld && q.size() + ((k >= 0 && !stall) ? 1 : 0) < 4) q.push_back(n);
    endtask

    task automatic cyc();
        @(negedge clk);
        check();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic clr();
        rst_clk = 0; flush = 0; dis_vld = 0; stall = 0; cv = '0;
        iid = 0; op = 0; f7 = 0; f3 = 0; s1v = 0; s1 = 0; s1r = 0;
        s2v = 0; s2 = 0; s2r = 0; dv = 0; pd = 0;
        for (int c = 0; c < 4; c++) cp[c] = '0;
    endtask

    task automatic dis(input logic [4:0] i, input logic [5:0] a, input logic ar,
                       input logic [5:0] b, input logic br);
        dis_vld = 1; iid = i; op = 7'h33 + 7'(i); f7 = 7'(i) ^ 7'h20; f3 = 3'(i);
        s1v = 1; s1 = a; s1r = ar; s2v = 1; s2 = b; s2r = br; dv = 1; pd = 6'(i) + 6'd32;
    endtask

    initial begin
        clr();
        rst_clk = 1;
        cyc();
        clr();
        cyc();
        dis(3, 1, 1, 2, 1); cyc();
        clr(); cyc(); cyc();
        dis(1, 10, 0, 2, 1); cyc();
        dis(2, 3, 1, 4, 1); cyc();
        clr(); cyc(); cyc();
        cv[0] = 1; cp[0] = 10; cyc();
        clr(); cyc(); cyc();
        for (int i = 0; i < 5; i++) begin
            dis(5'(i), 1, 1, 2, 1);
            stall = 1;
            cyc();
        end
        clr();
        for (int i = 0; i < 5; i++) cyc();
        for (int i = 0; i < 3; i++) begin
            dis(5'(8 + i), 1, 1, 2, 1);
            stall = 1;
            cyc();
        end
        dis(20, 1, 1, 2, 1); flush = 1; stall = 0; cyc();
        clr(); cyc();
        dis(5, 1, 1, 7, 0); cv[3] = 1; cp[3] = 7; cyc();
        clr(); cyc(); cyc();
        for (int i = 0; i < 2; i++) begin
            dis(5'(12 + i), 1, 1, 2, 1);
            stall = 1;
            cyc();
        end
        clr(); rst_clk = 1; cyc();
        clr(); cyc();
        for (int n = 0; n < 600; n++) begin
            clr();
            if ($urandom_range(99) < 60)
                dis(5'($urandom), 6'($urandom_range(15)), 1'($urandom), 6'($urandom_range(15)), 1'($urandom));
            s1v = dis_vld & ($urandom_range(3) != 0);
            s2v = dis_vld & ($urandom_range(3) != 0);
            for (int c = 0; c < 4; c++) begin
                cv[c] = ($urandom_range(9) < 3);
                cp[c] = 6'($urandom_range(15));
            end
            stall = ($urandom_range(3) == 0);
            flush = ($urandom_range(99) < 3);
            rst_clk = ($urandom_range(99) < 1);
            cyc();
        end
        clr();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end
endmodule
